// File: rtl/cve2_md_seq.sv
// Iterative multiply/divide sequencer: radix-2 shift-add multiply and restoring divide.
// Borrows an external 33-bit adder during iteration and fixes up signs at the end.
module cve2_md_seq #(
    parameter bit EarlyDivZero = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic        signed_a_i,
    input  logic        signed_b_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic        kill_i,
    output logic        busy_o,
    output logic        valid_o,
    output logic [31:0] result_o,
    output logic        alu_req_o,
    output logic [32:0] alu_a_o,
    output logic [32:0] alu_b_o,
    output logic        alu_sub_o,
    input  logic [32:0] alu_res_i
);
    localparam logic [1:0] MD_OP_MULL = 2'd0;
    localparam logic [1:0] MD_OP_MULH = 2'd1;
    localparam logic [1:0] MD_OP_DIV  = 2'd2;
    localparam logic [1:0] MD_OP_REM  = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_ABS, S_ITER, S_FIX, S_DONE} state_e;

    state_e      r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_result;
    logic [1:0]  r_op;
    logic        r_sa, r_sb;
    logic [31:0] r_a, r_b;
    logic        r_aneg, r_bneg, r_bzero;
    logic [31:0] r_hi, r_lo;

    logic        w_accept;
    logic        w_is_div;
    logic        w_aneg, w_bneg;
    logic [31:0] w_amag, w_bmag;
    logic [32:0] w_rem_sh;
    logic [32:0] w_alu_a, w_alu_b;
    logic        w_alu_sub;

    function automatic logic [31:0] f_result(input logic [1:0] op, input logic aneg,
                                             input logic bneg, input logic bzero,
                                             input logic [31:0] hi, input logic [31:0] lo);
        logic [63:0] prod;
        logic [31:0] res;
        prod = (aneg ^ bneg) ? (64'd0 - {hi, lo}) : {hi, lo};
        case (op)
            MD_OP_MULL: res = prod[31:0];
            MD_OP_MULH: res = prod[63:32];
            MD_OP_DIV:  res = ((aneg ^ bneg) && !bzero) ? (32'd0 - lo) : lo;
            default:    res = aneg ? (32'd0 - hi) : hi;
        endcase
        return res;
    endfunction

    assign w_accept = (r_state == S_IDLE) && start_i && !kill_i;
    assign w_is_div = r_op[1];
    assign w_aneg   = r_sa & r_a[31];
    assign w_bneg   = r_sb & r_b[31];
    assign w_amag   = w_aneg ? (32'd0 - r_a) : r_a;
    assign w_bmag   = w_bneg ? (32'd0 - r_b) : r_b;
    assign w_rem_sh = {r_hi, r_lo[31]};

    always_comb begin
        w_alu_a   = '0;
        w_alu_b   = '0;
        w_alu_sub = 1'b0;
        if (r_state == S_ITER) begin
            if (w_is_div) begin
                w_alu_a   = w_rem_sh;
                w_alu_b   = {1'b0, r_b};
                w_alu_sub = 1'b1;
            end else begin
                w_alu_a = {1'b0, r_hi};
                w_alu_b = r_b[0] ? {1'b0, r_a} : 33'd0;
            end
        end
    end

    assign busy_o    = (r_state != S_IDLE);
    assign valid_o   = (r_state == S_DONE);
    assign result_o  = r_result;
    assign alu_req_o = (r_state == S_ITER);
    assign alu_a_o   = w_alu_a;
    assign alu_b_o   = w_alu_b;
    assign alu_sub_o = w_alu_sub;

    // control: state, iteration counter, committed result
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) r_state <= S_ABS;
                S_ABS: begin
                    r_cnt <= 5'd31;
                    if (kill_i) begin
                        r_state <= S_IDLE;
                    end else if (EarlyDivZero && w_is_div && (r_b == 32'd0)) begin
                        r_result <= r_op[0] ? r_a : 32'hFFFF_FFFF;
                        r_state  <= S_DONE;
                    end else begin
                        r_state <= S_ITER;
                    end
                end
                S_ITER: begin
                    r_cnt <= r_cnt - 5'd1;
                    if (kill_i)              r_state <= S_IDLE;
                    else if (r_cnt == 5'd0)  r_state <= S_FIX;
                end
                S_FIX: begin
                    if (kill_i) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_result <= f_result(r_op, r_aneg, r_bneg, r_bzero, r_hi, r_lo);
                        r_state  <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // datapath: operand capture, magnitudes, shift-add / restoring-divide step
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_op <= op_i;
            r_sa <= signed_a_i;
            r_sb <= signed_b_i;
            r_a  <= op_a_i;
            r_b  <= op_b_i;
        end else if (r_state == S_ABS) begin
            r_aneg  <= w_aneg;
            r_bneg  <= w_bneg;
            r_bzero <= (r_b == 32'd0);
            r_a     <= w_amag;
            r_b     <= w_bmag;
            r_hi    <= '0;
            r_lo    <= w_is_div ? w_amag : 32'd0;
        end else if (r_state == S_ITER) begin
            if (w_is_div) begin
                r_hi <= alu_res_i[32] ? w_rem_sh[31:0] : alu_res_i[31:0];
                r_lo <= {r_lo[30:0], ~alu_res_i[32]};
            end else begin
                r_hi <= alu_res_i[32:1];
                r_lo <= {alu_res_i[0], r_lo[31:1]};
                r_b  <= {1'b0, r_b[31:1]};
            end
        end
    end
endmodule

// File: tb/tb_cve2_md_seq.sv
// Scoreboard bench for cve2_md_seq: directed corner cases plus randomized ops with kills.
module tb_cve2_md_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, kill, sa, sb;
    logic [1:0]  op;
    logic [31:0] a, b, res;
    logic        busy, valid, req, sub;
    logic [32:0] aa, ab, ares;

    logic        e_start, e_kill, e_sa, e_sb;
    logic [1:0]  e_op;
    logic [31:0] e_a, e_b, e_res;
    logic        e_busy, e_valid, e_req, e_sub;
    logic [32:0] e_aa, e_ab, e_ares;

    always_comb ares   = sub ? (aa - ab) : (aa + ab);
    always_comb e_ares = e_sub ? (e_aa - e_ab) : (e_aa + e_ab);

    cve2_md_seq #(.EarlyDivZero(1'b0)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .op_i(op),
        .signed_a_i(sa), .signed_b_i(sb), .op_a_i(a), .op_b_i(b), .kill_i(kill),
        .busy_o(busy), .valid_o(valid), .result_o(res), .alu_req_o(req),
        .alu_a_o(aa), .alu_b_o(ab), .alu_sub_o(sub), .alu_res_i(ares));

    cve2_md_seq #(.EarlyDivZero(1'b1)) dut_e (
        .clk_i(clk), .rst_ni(rst_n), .start_i(e_start), .op_i(e_op),
        .signed_a_i(e_sa), .signed_b_i(e_sb), .op_a_i(e_a), .op_b_i(e_b), .kill_i(e_kill),
        .busy_o(e_busy), .valid_o(e_valid), .result_o(e_res), .alu_req_o(e_req),
        .alu_a_o(e_aa), .alu_b_o(e_ab), .alu_sub_o(e_sub), .alu_res_i(e_ares));

    typedef struct { logic [31:0] res; int cyc; } exp_t;
    exp_t        sb_q[$];
    int          n_cmp = 0, n_fail = 0;
    int          cyc = 0;
    logic [31:0] exp_last = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain 64-bit arithmetic with RISC-V M-extension corner rules
    function automatic logic [31:0] ref_md(input logic [1:0] o, input bit s_a, input bit s_b,
                                           input logic [31:0] va, input logic [31:0] vb);
        logic signed [63:0] ea, eb, t;
        ea = s_a ? {{32{va[31]}}, va} : {32'd0, va};
        eb = s_b ? {{32{vb[31]}}, vb} : {32'd0, vb};
        case (o)
            2'd0: begin t = ea * eb; return t[31:0]; end
            2'd1: begin t = ea * eb; return t[63:32]; end
            2'd2: begin if (vb == 0) return 32'hFFFF_FFFF; t = ea / eb; return t[31:0]; end
            default: begin if (vb == 0) return va; t = ea % eb; return t[31:0]; end
        endcase
    endfunction

    always @(negedge clk) begin
        if (valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_valid", {63'd0, valid}, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("result", {32'd0, res}, {32'd0, e.res});
                chk("latency", 64'(cyc), 64'(e.cyc));
                exp_last = e.res;
            end
        end
        if (!req) chk("alu_idle_zero", {31'd0, aa | ab}, 64'd0);
    end

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_valid"}, {63'd0, valid}, 64'd0);
        chk({tag, "_req"}, {63'd0, req}, 64'd0);
        chk({tag, "_sub"}, {63'd0, sub}, 64'd0);
        chk({tag, "_result"}, {32'd0, res}, 64'd0);
        chk({tag, "_alu_a"}, {31'd0, aa}, 64'd0);
        chk({tag, "_alu_b"}, {31'd0, ab}, 64'd0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && busy; i++) @(negedge clk);
        chk("idle_timeout", {63'd0, busy}, 64'd0);
    endtask

    task automatic do_op(input logic [1:0] o, input bit s_a, input bit s_b,
                         input logic [31:0] va, input logic [31:0] vb,
                         input bit use_exp, input logic [31:0] exp_res,
                         input int kill_at, input bit hold, output int c);
        exp_t e;
        wait_idle();
        c = cyc;
        op = o; sa = s_a; sb = s_b; a = va; b = vb; start = 1'b1;
        if (kill_at == 0 || kill_at >= 35) begin
            e.res = use_exp ? exp_res : ref_md(o, s_a, s_b, va, vb);
            e.cyc = c + 35;
            sb_q.push_back(e);
        end
        @(negedge clk);
        if (!hold) start = 1'b0;
        op = 2'($urandom); sa = 1'($urandom); sb = 1'($urandom); a = $urandom; b = $urandom;
        if (kill_at > 0) begin
            repeat (kill_at - 1) @(negedge clk);
            kill = 1'b1;
            @(negedge clk);
            kill = 1'b0;
            if (kill_at < 35) begin
                chk("kill_busy", {63'd0, busy}, 64'd0);
                chk("kill_hold", {32'd0, res}, {32'd0, exp_last});
            end
        end
        if (hold) begin
            repeat (35) @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic e_run(input logic [1:0] o, input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] exp_res, input int exp_lat);
        int c, got;
        logic [31:0] gr;
        got = -1; gr = 'x;
        c = cyc;
        e_op = o; e_a = va; e_b = vb; e_start = 1'b1;
        @(negedge clk);
        e_start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (e_valid) begin got = cyc - c; gr = e_res; break; end
            @(negedge clk);
        end
        chk("early_latency", 64'(got), 64'(exp_lat));
        chk("early_result", {32'd0, gr}, {32'd0, exp_res});
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, bad, ka;
        logic [31:0] ra, rb;
        rst_n = 1'b0; start = 1'b0; kill = 1'b0; sa = 1'b0; sb = 1'b0; op = '0; a = '0; b = '0;
        e_start = 1'b0; e_kill = 1'b0; e_sa = 1'b0; e_sb = 1'b0; e_op = '0; e_a = '0; e_b = '0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        do_op(2'd0, 0, 0, 32'd7, 32'd6, 1, 32'd42, 0, 0, c);
        bad = 0;
        for (int k = 1; k <= 35; k++) begin
            if (req !== ((k >= 2) && (k <= 33))) bad++;
            @(negedge clk);
        end
        chk("req_window", 64'(bad), 64'd0);

        do_op(2'd1, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'h0000_0000, 0, 0, c);
        do_op(2'd1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 0, 0, c);
        do_op(2'd1, 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0, 0, c);
        do_op(2'd2, 1, 1, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFD, 0, 0, c);
        do_op(2'd3, 1, 1, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 0, 0, c);
        do_op(2'd2, 0, 0, 32'd100, 32'd7, 1, 32'd14, 0, 0, c);
        do_op(2'd3, 0, 0, 32'd100, 32'd7, 1, 32'd2, 0, 0, c);
        do_op(2'd2, 0, 0, 32'h1234, 32'd0, 1, 32'hFFFF_FFFF, 0, 0, c);
        do_op(2'd3, 0, 0, 32'h1234, 32'd0, 1, 32'h1234, 0, 0, c);
        do_op(2'd2, 1, 1, 32'h1234, 32'd0, 1, 32'hFFFF_FFFF, 0, 0, c);
        do_op(2'd3, 1, 1, 32'hFFFF_FFFB, 32'd0, 1, 32'hFFFF_FFFB, 0, 0, c);
        do_op(2'd2, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 0, 0, c);
        do_op(2'd3, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0000_0000, 0, 0, c);

        // kill at cycle 10, then restart at cycle 12
        do_op(2'd2, 0, 0, 32'd100, 32'd7, 1, 32'd14, 10, 0, c);
        @(negedge clk);
        do_op(2'd2, 0, 0, 32'd100, 32'd7, 1, 32'd14, 0, 0, c);

        // start held high for the whole op, including DONE
        do_op(2'd3, 0, 0, 32'd100, 32'd7, 1, 32'd2, 0, 1, c);

        // kill and start together in IDLE
        wait_idle();
        start = 1'b1; kill = 1'b1; op = 2'd0; a = 32'd3; b = 32'd3;
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        chk("kill_start_idle", {63'd0, busy}, 64'd0);

        // asynchronous reset in the middle of an op
        do_op(2'd0, 0, 0, 32'd12345, 32'd678, 1, 32'd8_369_910, 0, 0, c);
        repeat (19) @(negedge clk);
        rst_n = 1'b0; start = 1'b1;
        #1 chk_zero("midreset");
        @(negedge clk);
        chk_zero("midreset_hold");
        sb_q.delete();
        exp_last = '0;
        start = 1'b0; rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0: ra = 32'd0; 1: ra = 32'd1; 2: ra = 32'hFFFF_FFFF; 3: ra = 32'h8000_0000;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: rb = 32'd0; 1: rb = 32'd1; 2: rb = 32'hFFFF_FFFF; 3: rb = 32'h8000_0000;
                default: rb = $urandom;
            endcase
            ka = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 35)) : 0;
            do_op(2'($urandom), 1'($urandom), 1'($urandom), ra, rb, 0, 32'd0, ka, 0, c);
        end

        for (int i = 0; i < 100 && sb_q.size() > 0; i++) @(negedge clk);
        chk("drain", 64'(sb_q.size()), 64'd0);

        e_run(2'd2, 32'h1234, 32'd0, 32'hFFFF_FFFF, 2);
        e_run(2'd3, 32'h1234, 32'd0, 32'h1234, 2);
        e_run(2'd2, 32'd100, 32'd7, 32'd14, 35);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
